// File: rtl/mips_pkg.sv
// mips_pkg: shared hazard-controller types and register-tag constants.
package mips_pkg;
  localparam int TAG_W = 5;
  localparam logic [TAG_W-1:0] REG_ZERO = '0;
  typedef enum logic [1:0] {RUN, BR_WAIT2, MEMWAIT} state_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: compares ID source tags against EX/MEM destination tags.
module hazard_match
  import mips_pkg::*;
#(
  parameter int W = TAG_W
) (
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  input  logic         use_rs,
  input  logic         use_rt,
  input  logic [W-1:0] ex_dst,
  input  logic [W-1:0] mem_dst,
  output logic         ex_match,
  output logic         mem_match
);
  always_comb begin
    ex_match  = (ex_dst != W'(REG_ZERO)) && ((use_rs && ex_dst == rs) || (use_rt && ex_dst == rt));
    mem_match = (mem_dst != W'(REG_ZERO)) && ((use_rs && mem_dst == rs) || (use_rt && mem_dst == rt));
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush/freeze sequencing for the 5-stage MIPS pipeline.
module hazard_stall_ctrl
  import mips_pkg::*;
#(
  parameter int REG_W    = TAG_W,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_taken,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_memread,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             wait_timeout
);
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic wait_timeout_q, wait_timeout_d;
  logic ex_match, mem_match, br_ex_load, hazard, stall;
  hazard_match #(.W(REG_W)) u_match (
    .rs(id_rs), .rt(id_rt), .use_rs(id_use_rs), .use_rt(id_use_rt),
    .ex_dst(ex_dst), .mem_dst(mem_dst), .ex_match(ex_match), .mem_match(mem_match)
  );
  always_comb begin
    br_ex_load = id_branch && ex_match && ex_memread;
    hazard = (ex_memread && ex_match)
          || (id_branch && ex_match && ex_regwrite)
          || br_ex_load
          || (id_branch && mem_match && mem_memread);
    // a memory wait freezes everything, so hazards wait until it clears
    stall = !dmem_wait && (state_q == BR_WAIT2 || hazard);
    pc_write    = rst_n && !dmem_wait && !stall;
    ifid_stall  = rst_n && (dmem_wait || stall);
    ifid_flush  = !rst_n || (!dmem_wait && !stall && id_taken);
    idex_bubble = !rst_n || stall;
    freeze      = rst_n && dmem_wait;
    state_d = dmem_wait ? MEMWAIT : (state_q != BR_WAIT2 && br_ex_load) ? BR_WAIT2 : RUN;
    stall_cycles_d = stall_cycles_q + CNT_W'(!pc_write);
    wait_cnt_d = !dmem_wait ? '0 : (wait_cnt_q == WC_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
    wait_timeout_d = wait_timeout_q || (wait_cnt_d == WC_W'(MAX_WAIT));
    stall_cycles = stall_cycles_q;
    wait_timeout = wait_timeout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      stall_cycles_q <= '0;
      wait_cnt_q     <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
      wait_cnt_q     <= wait_cnt_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic id_use_rs, id_use_rt, id_branch, id_taken, ex_regwrite, ex_memread, mem_memread, dmem_wait;
  logic pc_write, ifid_stall, ifid_flush, idex_bubble, freeze, wait_timeout;
  logic [31:0] stall_cycles;
  typedef struct packed {
    logic pc, st, fl, bub, frz;
    logic [31:0] cnt;
    logic to;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;
  int model_cnt = 0, model_wcnt = 0;
  logic model_to = 1'b0;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.REG_W(5), .CNT_W(32), .MAX_WAIT(64)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_branch(id_branch), .id_taken(id_taken), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_dst(mem_dst),
    .mem_memread(mem_memread), .dmem_wait(dmem_wait), .pc_write(pc_write),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .freeze(freeze), .stall_cycles(stall_cycles), .wait_timeout(wait_timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic ut,
                       input logic br, input logic tk, input logic [4:0] exd, input logic exw,
                       input logic exm, input logic [4:0] md, input logic mm, input logic dw);
    id_rs = rs; id_rt = rt; id_use_rs = ur; id_use_rt = ut; id_branch = br; id_taken = tk;
    ex_dst = exd; ex_regwrite = exw; ex_memread = exm; mem_dst = md; mem_memread = mm; dmem_wait = dw;
  endtask
  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask
  task automatic step(input logic pc, input logic st, input logic fl, input logic bub, input logic frz);
    exp_t e;
    e.pc = pc; e.st = st; e.fl = fl; e.bub = bub; e.frz = frz;
    e.cnt = model_cnt; e.to = model_to;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("pc_write", {31'd0, pc_write}, {31'd0, e.pc});
    chk("ifid_stall", {31'd0, ifid_stall}, {31'd0, e.st});
    chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, e.fl});
    chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, e.bub});
    chk("freeze", {31'd0, freeze}, {31'd0, e.frz});
    chk("stall_cycles", stall_cycles, e.cnt);
    chk("wait_timeout", {31'd0, wait_timeout}, {31'd0, e.to});
    @(posedge clk);
    if (!rst_n) begin
      model_cnt = 0; model_wcnt = 0; model_to = 1'b0;
    end else begin
      if (!e.pc) model_cnt++;
      model_wcnt = dmem_wait ? ((model_wcnt < 64) ? model_wcnt + 1 : 64) : 0;
      if (model_wcnt == 64) model_to = 1'b1;
    end
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    step(0, 0, 1, 1, 0);
    rst_n = 1'b1;
    idle(); step(1, 0, 0, 0, 0);
    drive(5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0); step(0, 1, 0, 1, 0);
    idle(); step(1, 0, 0, 0, 0);
    drive(5'd0, 5'd8, 0, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0); step(1, 0, 0, 0, 0);
    drive(5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 1, 1, 5'd0, 0, 0); step(1, 0, 1, 0, 0);
    drive(5'd9, 5'd0, 1, 0, 1, 0, 5'd9, 1, 1, 5'd0, 0, 0); step(0, 1, 0, 1, 0);
    drive(5'd9, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); step(0, 1, 0, 1, 0);
    drive(5'd9, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); step(1, 0, 1, 0, 0);
    idle(); step(1, 0, 0, 0, 0);
    drive(5'd0, 5'd5, 0, 1, 1, 0, 5'd5, 1, 0, 5'd0, 0, 0); step(0, 1, 0, 1, 0);
    idle(); step(1, 0, 0, 0, 0);
    drive(5'd7, 5'd0, 1, 0, 1, 0, 5'd0, 0, 0, 5'd7, 1, 0); step(0, 1, 0, 1, 0);
    drive(5'd7, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd7, 1, 0); step(1, 0, 0, 0, 0);
    drive(5'd7, 5'd0, 1, 0, 1, 0, 5'd0, 0, 0, 5'd7, 0, 0); step(1, 0, 0, 0, 0);
    repeat (3) begin
      drive(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 1, 1, 5'd0, 0, 1); step(0, 1, 0, 0, 1);
    end
    drive(5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0); step(0, 1, 0, 1, 0);
    idle(); step(1, 0, 0, 0, 0);
    repeat (70) begin
      drive(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1); step(0, 1, 0, 0, 1);
    end
    idle(); step(1, 0, 0, 0, 0);
    idle(); step(1, 0, 0, 0, 0);
    drive(5'd9, 5'd0, 1, 0, 1, 0, 5'd9, 1, 1, 5'd0, 0, 0); step(0, 1, 0, 1, 0);
    rst_n = 1'b0;
    drive(5'd9, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); step(0, 0, 1, 1, 0);
    rst_n = 1'b1;
    idle(); step(1, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It sequences the PC register, the IF/ID register (stall/flush), ID/EX (bubble insertion) and the later stages (global freeze).
- Detects load-use and branch-operand hazards from ID/EX/MEM register tags.
- Handles taken-branch/jump flush and data-memory wait states.
- Keeps stall statistics and a memory-wait watchdog.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 32, width of the stall-cycle performance counter
MAX_WAIT, 64, dmem_wait cycles before wait_timeout is raised

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
id_rs  in  REG_W  rs field of the instruction in ID
id_rt  in  REG_W  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a conditional branch (compared in ID)
id_taken  in  1  branch/jump in ID resolves taken this cycle
ex_dst  in  REG_W  destination register of EX instruction
ex_regwrite  in  1  EX instruction writes a register
ex_memread  in  1  EX instruction is a load
mem_dst  in  REG_W  destination register of MEM instruction
mem_memread  in  1  MEM instruction is a load
dmem_wait  in  1  data memory not ready; MEM access must be held
pc_write  out  1  PC may update
ifid_stall  out  1  IF/ID holds its value
ifid_flush  out  1  IF/ID loads 32'b0 (NOP)
idex_bubble  out  1  ID/EX loads control-zero bubble
freeze  out  1  EX/MEM and MEM/WB hold
stall_cycles  out  CNT_W  count of cycles with pc_write==0
wait_timeout  out  1  sticky: dmem_wait exceeded MAX_WAIT

Behaviour:
- A match requires dst != 0 and dst == a source that the ID instruction uses.
- Control outputs are combinational from state and inputs, so they act in the same cycle the hazard sits in ID. State, counters and wait_timeout are registered.
- rst_n==0 (combinational override): pc_write=0, ifid_stall=0, ifid_flush=1, idex_bubble=1, freeze=0. The pipeline fills with NOPs.
- At a clock edge with rst_n==0: state=RUN, stall_cycles=0, wait_timeout=0, wait counter=0. A reset during any stall abandons it; no pending stall survives.
- FSM states: RUN, BR_WAIT2, MEMWAIT.
- Priority (highest first): dmem_wait > data hazard > taken flush.
- dmem_wait=1, any state: freeze=1, pc_write=0, ifid_stall=1, idex_bubble=0 (ID/EX holds).
  - Next state is MEMWAIT; it returns to RUN the cycle after dmem_wait falls.
  - Hazard checks are suppressed while frozen and re-evaluated on return.
- Load-use: ex_memread and match. Outputs pc_write=0, ifid_stall=1, idex_bubble=1 for exactly 1 cycle.
- Branch hazards (id_branch=1):
  - EX ALU result match (ex_regwrite, not load): 1 stall.
  - EX load match: 2 stalls. Cycle 1 is in RUN; transition to BR_WAIT2, which forces one more stall cycle, then back to RUN.
  - MEM load match: 1 stall.
- Taken flush: id_taken=1 with no hazard. Outputs ifid_flush=1, pc_write=1, ifid_stall=0 for 1 cycle. If a hazard stall is active, the flush is deferred; id_taken is re-sampled once the stall clears.
- ifid_stall and ifid_flush are never both 1.
- stall_cycles increments (wraps modulo 2^CNT_W) on every non-reset cycle with pc_write==0.
- Wait counter:
  - Counts consecutive dmem_wait cycles and saturates at MAX_WAIT.
  - wait_timeout sets when the counter reaches MAX_WAIT and stays set until reset.
  - The counter clears when dmem_wait=0.

Decomposition:
- Shared package (mips_pkg): FSM state enum (RUN/BR_WAIT2/MEMWAIT), REG_ZERO constant, register-tag width.
- One natural sub-module: hazard_match. It is a combinational tag comparator producing ex_match/mem_match for rs/rt, instantiated once.

Test Plan:
- Load-use: lw $8 in EX, add reading $8 in ID → 1 cycle of pc_write=0, ifid_stall=1, idex_bubble=1; stall_cycles 0→1.
- Branch after load: lw $9 in EX, beq $9 in ID → 2 consecutive stall cycles (state RUN→BR_WAIT2→RUN); stall_cycles +2.
- Taken jump with no hazard: id_taken=1 → ifid_flush=1, pc_write=1 for one cycle; $0 destination (ex_dst=0, ex_memread=1) → no stall.
- dmem_wait held 3 cycles during a load-use hazard → freeze=1 for 3 cycles, then the 1-cycle load-use stall; stall_cycles +4.
- dmem_wait held 70 cycles with MAX_WAIT=64 → wait_timeout rises on wait cycle 64 and stays 1 after dmem_wait drops.
- rst_n=0 asserted in BR_WAIT2 → next cycle state RUN, counters 0, ifid_flush=1 while rst_n=0.
